// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and state encoding for the FIFO write-side feeder
package fifo_pkg;

  localparam int DW      = 4;
  localparam int DEF_LEN = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/skid_buf2.sv
// rtl/skid_buf2.sv - 2-entry push/pop buffer with a registered head entry
module skid_buf2 #(
  parameter int DW = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_head,
  output logic          o_full,
  output logic          o_empty
);

  logic [DW-1:0] r_head;
  logic [DW-1:0] r_tail;
  logic [1:0]    r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == 2'd2);
  assign o_empty = (r_cnt == 2'd0);
  assign o_head  = r_head;

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_head <= i_data;
          else               r_tail <= i_data;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_head <= r_tail;
          r_cnt  <= r_cnt - 2'd1;
        end
        // Push and pop together: occupancy holds, the new word lands behind any survivor.
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_head <= i_data;
          end else begin
            r_head <= r_tail;
            r_tail <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_write_ctrl.sv
// rtl/fifo_write_ctrl.sv - burst-framed FIFO write feeder; SEQ_CHECK_EN adds a sequence checker
module fifo_write_ctrl
  import fifo_pkg::*;
#(
  parameter int DW      = fifo_pkg::DW,
  parameter int CNT_W   = 8,
  parameter int DEF_LEN = fifo_pkg::DEF_LEN
) (
  input  logic             write_clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic             s_valid,
  input  logic [DW-1:0]    s_data,
  output logic             s_ready,
  input  logic             writable,
  output logic             we,
  output logic             din_a,
  output logic             din_b,
  output logic             din_c,
  output logic             din_d,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] wr_count_o
`ifdef SEQ_CHECK_EN
  ,
  output logic             seq_err_o
`endif
);

  state_e           r_state;
  logic [CNT_W-1:0] r_target;
  logic [CNT_W-1:0] r_acc;
  logic [CNT_W-1:0] r_wr_count;

  logic [DW-1:0]    w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_busy;
  logic             w_s_ready;
  logic             w_push;
  logic             w_we;
  logic             w_last_wr;
  logic             w_start;

  assign w_busy    = (r_state != ST_IDLE);
  assign w_start   = (r_state == ST_IDLE) && start_i;
  assign w_s_ready = !rst && (r_state == ST_RUN) && !w_full && (r_acc < r_target);
  assign w_push    = s_valid && w_s_ready;
  // No write may escape in the reset cycle, so the write strobe is gated by rst directly.
  assign w_we      = !rst && w_busy && !w_empty && writable;
  assign w_last_wr = w_we && (r_wr_count == (r_target - CNT_W'(1)));

  skid_buf2 #(
    .DW(DW)
  ) u_skid (
    .i_clk   (write_clk),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_data  (s_data),
    .i_pop   (w_we),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge write_clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_target   <= '0;
      r_acc      <= '0;
      r_wr_count <= '0;
    end else begin
      if (w_we)   r_wr_count <= r_wr_count + CNT_W'(1);
      if (w_push) r_acc      <= r_acc + CNT_W'(1);
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_target   <= (len_i == '0) ? CNT_W'(DEF_LEN) : len_i;
            r_acc      <= '0;
            r_wr_count <= '0;
            r_state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_push && (r_acc == (r_target - CNT_W'(1)))) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_last_wr) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef SEQ_CHECK_EN
  logic [DW-1:0] r_prev;
  logic          r_have_prev;
  logic          r_seq_err;

  always_ff @(posedge write_clk) begin
    if (rst) begin
      r_prev      <= '0;
      r_have_prev <= 1'b0;
      r_seq_err   <= 1'b0;
    end else if (w_start) begin
      r_have_prev <= 1'b0;
      r_seq_err   <= 1'b0;
    end else if (w_push) begin
      r_prev      <= s_data;
      r_have_prev <= 1'b1;
      if (r_have_prev && (s_data != (r_prev + DW'(1)))) r_seq_err <= 1'b1;
    end
  end

  assign seq_err_o = r_seq_err;
`endif

  assign s_ready    = w_s_ready;
  assign we         = w_we;
  assign din_a      = w_head[0];
  assign din_b      = w_head[1];
  assign din_c      = w_head[2];
  assign din_d      = w_head[3];
  assign busy_o     = w_busy;
  assign done_o     = w_last_wr;
  assign wr_count_o = r_wr_count;

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// tb/tb_fifo_write_ctrl.sv - directed self-checking bench for fifo_write_ctrl
module tb_fifo_write_ctrl;

  logic       write_clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic [7:0] len_i;
  logic       s_valid;
  logic [3:0] s_data;
  logic       s_ready;
  logic       writable;
  logic       we;
  logic       din_a, din_b, din_c, din_d;
  logic       busy_o;
  logic       done_o;
  logic [7:0] wr_count_o;
`ifdef SEQ_CHECK_EN
  logic       seq_err_o;
`endif

  fifo_write_ctrl dut (
    .write_clk  (write_clk),
    .rst        (rst),
    .start_i    (start_i),
    .len_i      (len_i),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .writable   (writable),
    .we         (we),
    .din_a      (din_a),
    .din_b      (din_b),
    .din_c      (din_c),
    .din_d      (din_d),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .wr_count_o (wr_count_o)
`ifdef SEQ_CHECK_EN
    ,
    .seq_err_o  (seq_err_o)
`endif
  );

  always #5 write_clk = ~write_clk;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [3:0] src [64];
  logic [3:0] got [64];
  int         nwr, ndone, acc, first_c, last_c, stall_we, done_wr, sready_low;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drives one burst: counting source from src[], writable low on cycles st_lo..st_hi,
  // optional stray start_i on cycle mid_c, optional early stop after max_wr writes.
  task automatic run_burst(input int len, input int st_lo, input int st_hi,
                           input int mid_c, input int max_wr);
    int len_eff;
    len_eff = (len == 0) ? 8 : len;
    nwr = 0; ndone = 0; acc = 0; first_c = -1; last_c = -1;
    stall_we = 0; done_wr = -1; sready_low = 0;
    start_i = 1'b1; len_i = 8'(len); s_valid = 1'b0; writable = 1'b1;
    @(posedge write_clk); #1;
    start_i = 1'b0;
    for (int c = 0; c < 100; c++) begin
      s_valid  = 1'b1;
      s_data   = src[acc % 64];
      writable = (c >= st_lo && c <= st_hi) ? 1'b0 : 1'b1;
      start_i  = (c == mid_c);
      len_i    = (c == mid_c) ? 8'd3 : 8'(len);
      #1;
      if (s_ready) acc++;
      else if (busy_o && acc < len_eff) sready_low++;
      if (we) begin
        if (nwr < 64) got[nwr] = {din_d, din_c, din_b, din_a};
        nwr++;
        if (first_c < 0) first_c = c;
        last_c = c;
        if (c >= st_lo && c <= st_hi) stall_we++;
      end
      if (done_o) begin
        ndone++;
        done_wr = nwr;
      end
      @(posedge write_clk); #1;
      start_i = 1'b0;
      if (ndone > 0 || (max_wr > 0 && nwr >= max_wr)) break;
    end
    s_valid  = 1'b0;
    writable = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) src[i] = 4'(i + 1);
    rst = 1'b1; start_i = 1'b0; len_i = 8'd0; s_valid = 1'b0; s_data = 4'd0; writable = 1'b1;
    repeat (2) @(posedge write_clk);
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_we", we, 0);
    chk("rst_din", {din_d, din_c, din_b, din_a}, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_wr_count", wr_count_o, 0);
    rst = 1'b0;
    @(posedge write_clk); #1;
    chk("idle_s_ready", s_ready, 0);

    // Burst of 8, writable held high
    run_burst(8, 1000, -1, -1, 0);
    chk("b8_nwr", nwr, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("b8_word%0d", i), got[i], i + 1);
    chk("b8_ndone", ndone, 1);
    chk("b8_done_on_last", done_wr, 8);
    chk("b8_first_latency", first_c, 1);
    chk("b8_back_to_back", last_c - first_c, 7);
    chk("b8_wr_count", wr_count_o, 8);
    chk("b8_busy_after", busy_o, 0);
    chk("b8_s_ready_after", s_ready, 0);

    // Same burst, writable low on cycles 3..5
    run_burst(8, 3, 5, -1, 0);
    chk("stall_nwr", nwr, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("stall_word%0d", i), got[i], i + 1);
    chk("stall_we_in_stall", stall_we, 0);
    chk("stall_s_ready_low", sready_low, 3);
    chk("stall_last_write", last_c, 11);
    chk("stall_ndone", ndone, 1);
    chk("stall_wr_count", wr_count_o, 8);

    // len_i = 0 selects the default, stray start_i mid-burst ignored
    run_burst(0, 1000, -1, 3, 0);
    chk("def_nwr", nwr, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("def_word%0d", i), got[i], i + 1);
    chk("def_ndone", ndone, 1);
    chk("def_done_on_last", done_wr, 8);
    chk("def_wr_count", wr_count_o, 8);

    // Target of 1
    run_burst(1, 1000, -1, -1, 0);
    chk("one_nwr", nwr, 1);
    chk("one_word", got[0], 1);
    chk("one_done_on_last", done_wr, 1);
    chk("one_wr_count", wr_count_o, 1);

    // Reset after the 3rd write of a 6-word burst
    run_burst(6, 1000, -1, -1, 3);
    chk("mid_nwr", nwr, 3);
    chk("mid_busy", busy_o, 1);
    s_valid = 1'b1; writable = 1'b1; rst = 1'b1;
    #1;
    chk("rstcyc_we", we, 0);
    chk("rstcyc_s_ready", s_ready, 0);
    @(posedge write_clk); #1;
    rst = 1'b0; s_valid = 1'b0;
    #1;
    chk("post_rst_we", we, 0);
    chk("post_rst_busy", busy_o, 0);
    chk("post_rst_wr_count", wr_count_o, 0);
    chk("post_rst_s_ready", s_ready, 0);
    chk("post_rst_done", done_o, 0);
    run_burst(2, 1000, -1, -1, 0);
    chk("len2_nwr", nwr, 2);
    chk("len2_word0", got[0], 1);
    chk("len2_word1", got[1], 2);
    chk("len2_ndone", ndone, 1);
    chk("len2_wr_count", wr_count_o, 2);

`ifdef SEQ_CHECK_EN
    src[0] = 4'd1; src[1] = 4'd2; src[2] = 4'd4;
    run_burst(3, 1000, -1, -1, 0);
    chk("seq_nwr", nwr, 3);
    chk("seq_word0", got[0], 1);
    chk("seq_word1", got[1], 2);
    chk("seq_word2", got[2], 4);
    chk("seq_err_set", seq_err_o, 1);
    @(posedge write_clk); #1;
    chk("seq_err_sticky", seq_err_o, 1);
    for (int i = 0; i < 64; i++) src[i] = 4'(i + 1);
    run_burst(1, 1000, -1, -1, 0);
    chk("seq_err_cleared", seq_err_o, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_write_ctrl.md
Name: fifo_write_ctrl

Overview:
- Write-side feeder stage that sits directly upstream of the FIFO top. Accepts 4-bit words from a valid/ready source.
- Buffers them in a 2-entry skid buffer and drives the FIFO write port (we, din_a..din_d), gated by the FIFO's writable status.
- Frames transfers into bursts of programmable length, started by a start pulse; reports progress and completion.

Parameters:
- DW, 4, data width; fixed at 4 to match din_a..din_d.
- CNT_W, 8, width of the burst length and word counters.
- DEF_LEN, 8, burst length used when len_i == 0.

Ports:
- write_clk  in  1  system clock; everything is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle pulse; begins a burst (IDLE only).
- len_i  in  CNT_W  burst length, sampled on start_i; 0 selects DEF_LEN.
- s_valid  in  1  source word valid.
- s_data  in  DW  source word.
- s_ready  out  1  stage can accept a word.
- writable  in  1  FIFO can take a write this cycle.
- we  out  1  FIFO write enable.
- din_a, din_b, din_c, din_d  out  1 each  FIFO data bits 0..3.
- busy_o  out  1  burst in progress (RUN or DRAIN).
- done_o  out  1  one-cycle pulse when the last burst word is written.
- wr_count_o  out  CNT_W  words written in the current or last burst.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, skid buffer empty, counters 0.
  - Outputs: s_ready=0, we=0, din_*=0, busy_o=0, done_o=0, wr_count_o=0.
  - Reset mid-burst discards buffered words; no write is issued in the reset cycle.
- States:
  - IDLE: s_ready=0.
    - start_i=1 -> RUN. Latch target = (len_i==0 ? DEF_LEN : len_i). Clear accepted count and wr_count_o.
  - RUN: s_ready = (buffer not full) && (accepted < target).
    - A source word transfers on a cycle with s_valid && s_ready, pushed at the tail; accepted is incremented.
    - When accepted reaches target -> DRAIN.
  - DRAIN: s_ready=0.
    - When the buffer is empty and the final write has occurred -> IDLE, with done_o=1 on the clock of that final write.
- Write port:
  - we = (RUN or DRAIN) && buffer non-empty && writable. This is combinational from registered state and the writable input; there is no registered feedback on writable.
  - din_a..din_d = head entry bits 0..3. The head is registered and stable while we is low.
  - On a cycle with we=1, the head is popped and wr_count_o is incremented.
- Simultaneous push and pop in the same cycle is legal. Occupancy is unchanged and order is preserved.
- Data ordering: strict FIFO; no word is dropped or duplicated.
- Throughput: 1 word/cycle sustained while writable=1 and s_valid=1.
- Latency: a word accepted at edge N can appear on the write port at edge N+1 at the earliest.
- Back-pressure: writable=0 holds the buffer. When 2 entries are held, s_ready drops in the same cycle the buffer becomes full.
- start_i while busy_o=1 is ignored.
- A target of 1 is legal. target = 2^CNT_W-1 must not overflow the counters.

Optional Feature:
- Macro SEQ_CHECK_EN.
- When defined:
  - Adds output seq_err_o (1 bit, reset 0).
  - Each accepted word must equal the previous accepted word + 1 mod 16. The first word of a burst is unchecked.
  - A mismatch sets seq_err_o sticky until the next start_i or rst. Data flow is unaffected.
- When undefined: no port is added and no checker logic is present.

Decomposition:
- Shared package fifo_pkg:
  - DW constant.
  - State enum (IDLE, RUN, DRAIN).
  - DEF_LEN default.
- Sub-module: skid_buf2, a 2-entry push/pop buffer with full/empty flags, instantiated once.

Test Plan:
- Burst of 8, source counting 1..8, writable held 1:
  - 8 consecutive we pulses with din_{d,c,b,a} = 1..8.
  - done_o pulses on the 8th write; wr_count_o=8; then IDLE.
- Same burst with writable low on cycles 3-5:
  - we stays 0 during the stall and s_ready falls once 2 words are held.
  - No loss, order 1..8; resumes at 1 word/cycle.
- len_i=0:
  - Exactly DEF_LEN=8 writes, then done_o.
  - start_i mid-burst changes nothing.
- rst asserted after the 3rd write of a 6-word burst:
  - Next cycle: we=0, busy_o=0, wr_count_o=0, s_ready=0.
  - A new start_i with len 2 gives exactly 2 writes.
- With SEQ_CHECK_EN, source 1,2,4:
  - seq_err_o=1 after the 3rd acceptance and stays 1; all 3 words are still written.
  - The next start_i clears it.
